// File: rtl/prod_accumulator.sv
// Sums ACC_LEN unsigned products per frame; define PROD_ACC_SAT_EN to saturate instead of wrap on overflow.
// o_valid rises 1 cycle after the last input; in HOLD o_ready follows i_ready so a new frame can start with no bubble.
module prod_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_LEN    = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+3
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [2*DATA_WIDTH-1:0] i_product,
    input  logic                    i_clear,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [ACC_WIDTH-1:0]    o_acc,
    output logic                    o_overflow
);

    localparam int CW = $clog2(ACC_LEN + 1);

    generate
        if (ACC_LEN < 2) begin : g_bad_acc_len
            $error("prod_accumulator: ACC_LEN must be 2 or more");
        end
        if (ACC_WIDTH < 2*DATA_WIDTH) begin : g_bad_acc_width
            $error("prod_accumulator: ACC_WIDTH must be at least 2*DATA_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [CW-1:0]          r_count, w_count_nxt;
    logic [ACC_WIDTH-1:0]   r_acc, w_acc_nxt;
    logic                   r_ovf, w_ovf_nxt;

    logic                   w_in_xfer;
    logic                   w_out_xfer;
    logic [ACC_WIDTH-1:0]   w_prod_ext;
    logic [ACC_WIDTH:0]     w_sum;
    logic                   w_ovf_add;
    logic [ACC_WIDTH-1:0]   w_acc_add;

    assign o_ready    = (r_state == HOLD) ? i_ready : 1'b1;
    assign w_in_xfer  = i_valid && o_ready;
    assign w_out_xfer = (r_state == HOLD) && i_ready;

    assign w_prod_ext = ACC_WIDTH'(i_product);
    assign w_sum      = {1'b0, r_acc} + {1'b0, w_prod_ext};
    assign w_ovf_add  = r_ovf | w_sum[ACC_WIDTH];

`ifdef PROD_ACC_SAT_EN
    // Once saturated the sum stays pinned at all-ones until the frame ends.
    assign w_acc_add = w_ovf_add ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
`else
    assign w_acc_add = w_sum[ACC_WIDTH-1:0];
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_acc_nxt   = r_acc;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            IDLE: begin
                if (w_in_xfer) begin
                    w_acc_nxt   = w_prod_ext;
                    w_count_nxt = CW'(1);
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (w_in_xfer) begin
                    w_acc_nxt   = w_acc_add;
                    w_ovf_nxt   = w_ovf_add;
                    w_count_nxt = r_count + CW'(1);
                    if (r_count == CW'(ACC_LEN - 1)) begin
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (w_out_xfer) begin
                    // Simultaneous input opens the next frame in the same edge.
                    if (w_in_xfer) begin
                        w_acc_nxt   = w_prod_ext;
                        w_count_nxt = CW'(1);
                        w_state_nxt = ACCUM;
                    end else begin
                        w_acc_nxt   = '0;
                        w_count_nxt = '0;
                        w_state_nxt = IDLE;
                    end
                    w_ovf_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
                w_acc_nxt   = '0;
                w_ovf_nxt   = 1'b0;
            end
        endcase
        if (i_clear) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
            w_acc_nxt   = '0;
            w_ovf_nxt   = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_acc   <= w_acc_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign o_acc      = r_acc;
    assign o_valid    = (r_state == HOLD);
    assign o_overflow = r_ovf;

endmodule

// File: tb/tb_prod_accumulator.sv
// Drives a 35-bit and a 32-bit accumulator with identical stimulus and checks both against a frame-sum model.
module tb_prod_accumulator;

    localparam int DW  = 16;
    localparam int LEN = 4;
    localparam int WA  = 35;
    localparam int WB  = 32;

    logic            clk;
    logic            rst_n;
    logic            in_vld;
    logic [2*DW-1:0] in_dat;
    logic            clr;
    logic            out_rdy;
    logic            rdy_a, rdy_b;
    logic            vld_a, vld_b;
    logic [WA-1:0]   acc_a;
    logic [WB-1:0]   acc_b;
    logic            ovf_a, ovf_b;

    int n_tests = 0;
    int n_fail  = 0;

    bit              m_hold;
    int              m_cnt;
    longint unsigned m_sum;
    bit              m_after_rst;
    bit              m_after_clr;

    prod_accumulator #(.DATA_WIDTH(DW), .ACC_LEN(LEN), .ACC_WIDTH(WA)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_vld), .o_ready(rdy_a),
        .i_product(in_dat), .i_clear(clr), .o_valid(vld_a), .i_ready(out_rdy),
        .o_acc(acc_a), .o_overflow(ovf_a)
    );

    prod_accumulator #(.DATA_WIDTH(DW), .ACC_LEN(LEN), .ACC_WIDTH(WB)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_vld), .o_ready(rdy_b),
        .i_product(in_dat), .i_clear(clr), .o_valid(vld_b), .i_ready(out_rdy),
        .o_acc(acc_b), .o_overflow(ovf_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_acc(input longint unsigned s, input int w);
        logic [63:0] mx;
        mx = (64'd1 << w) - 64'd1;
        if (s > mx) begin
`ifdef PROD_ACC_SAT_EN
            return mx;
`else
            return s & mx;
`endif
        end
        return s;
    endfunction

    function automatic logic exp_ovf(input longint unsigned s, input int w);
        return s > ((64'd1 << w) - 64'd1);
    endfunction

    task automatic model_reset();
        m_hold = 1'b0;
        m_cnt  = 0;
        m_sum  = 0;
    endtask

    // One clock: drive at negedge, check against model, then advance the model at posedge.
    task automatic step(input bit v, input logic [31:0] p, input bit c, input bit r, input bit rst);
        bit in_x;
        @(negedge clk);
        in_vld  = v;
        in_dat  = p;
        clr     = c;
        out_rdy = r;
        rst_n   = ~rst;
        #1;
        chk("ready_a", rdy_a, m_hold ? r : 1'b1);
        chk("ready_b", rdy_b, m_hold ? r : 1'b1);
        chk("valid_a", vld_a, m_hold);
        chk("valid_b", vld_b, m_hold);
        if (m_hold) begin
            chk("acc_a", acc_a, exp_acc(m_sum, WA));
            chk("acc_b", acc_b, exp_acc(m_sum, WB));
            chk("ovf_a", ovf_a, exp_ovf(m_sum, WA));
            chk("ovf_b", ovf_b, exp_ovf(m_sum, WB));
        end
        if (m_after_rst) begin
            chk("rst_acc_a", acc_a, 0);
            chk("rst_acc_b", acc_b, 0);
        end
        if (m_after_rst || m_after_clr) begin
            chk("zero_ovf_a", ovf_a, 1'b0);
            chk("zero_ovf_b", ovf_b, 1'b0);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
            m_after_rst = 1'b1;
            m_after_clr = 1'b0;
        end else if (c) begin
            model_reset();
            m_after_clr = 1'b1;
            m_after_rst = 1'b0;
        end else begin
            in_x = v && (m_hold ? r : 1'b1);
            if (m_hold) begin
                if (r) begin
                    m_hold = 1'b0;
                    m_cnt  = in_x ? 1 : 0;
                    m_sum  = in_x ? longint'(p) : 0;
                end
            end else if (in_x) begin
                m_sum = (m_cnt == 0) ? longint'(p) : m_sum + longint'(p);
                m_cnt++;
                if (m_cnt == LEN) m_hold = 1'b1;
            end
            if (in_x) begin
                m_after_rst = 1'b0;
                m_after_clr = 1'b0;
            end
        end
    endtask

    task automatic frame4(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
        step(1, a, 0, 0, 0);
        step(1, b, 0, 0, 0);
        step(1, c, 0, 0, 0);
        step(1, d, 0, 0, 0);
    endtask

    initial begin
        in_vld = 0; in_dat = '0; clr = 0; out_rdy = 0; rst_n = 0;
        model_reset();
        m_after_rst = 1'b1;
        m_after_clr = 1'b0;
        repeat (2) @(posedge clk);

        // Basic frame, then held output with ignored input pulses.
        frame4(1, 2, 3, 4);
        #1;
        chk("sum1234_valid", vld_a, 1'b1);
        chk("sum1234_acc", acc_a, 10);
        chk("sum1234_ovf", ovf_a, 1'b0);
        for (int i = 0; i < 3; i++) step(i[0] ? 1'b0 : 1'b1, 32'd99, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        #1;
        chk("drain_idle", vld_a, 1'b0);
        chk("drain_ready", rdy_a, 1'b1);

        // No-bubble handoff into a frame starting with 7.
        frame4(2, 2, 2, 2);
        step(1, 7, 0, 1, 0);
        #1;
        chk("handoff_valid", vld_a, 1'b0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        #1;
        chk("handoff_acc", acc_a, 10);
        step(0, 0, 0, 1, 0);

        // Overflow of the 32-bit instance.
        frame4(32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001);
        #1;
`ifdef PROD_ACC_SAT_EN
        chk("big_acc_b", acc_b, 32'hFFFFFFFF);
`else
        chk("big_acc_b", acc_b, 32'hFFF80004);
`endif
        chk("big_ovf_b", ovf_b, 1'b1);
        chk("big_acc_a", acc_a, 64'h3FFF80004);
        chk("big_ovf_a", ovf_a, 1'b0);
        step(0, 0, 0, 1, 0);

        // Flush of a partial frame, clear-cycle product discarded.
        step(1, 9, 0, 0, 0);
        step(1, 9, 0, 0, 0);
        step(1, 9, 1, 0, 0);
        frame4(5, 5, 5, 5);
        #1;
        chk("clear_acc", acc_a, 20);
        step(0, 0, 0, 1, 0);

        // Reset during HOLD aborts the frame.
        frame4(6, 6, 6, 6);
        step(0, 0, 0, 0, 1);
        #1;
        chk("rst_valid", vld_a, 1'b0);
        chk("rst_ready", rdy_a, 1'b1);
        chk("rst_acc", acc_a, 0);
        frame4(3, 3, 3, 3);
        #1;
        chk("post_rst_acc", acc_a, 12);
        step(0, 0, 0, 1, 0);

        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 255),
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 79) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prod_accumulator.md
PROD_ACCUMULATOR -- requirements
Module: prod_accumulator

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, the multiplier operand width; the product width is 2*DATA_WIDTH.
REQ-002 The block SHALL have parameter ACC_LEN, default 8, the number of products summed per frame; legal range is 2 or more.
REQ-003 The block SHALL have parameter ACC_WIDTH, default 2*DATA_WIDTH+3, the accumulator width; it must be at least 2*DATA_WIDTH.
REQ-004 The block SHALL have port i_clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port i_rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port i_valid, input, 1 bit: i_product is valid.
REQ-007 The block SHALL have port o_ready, output, 1 bit: the block accepts a product this cycle.
REQ-008 The block SHALL have port i_product, input, 2*DATA_WIDTH bits: unsigned product from the upstream array multiplier.
REQ-009 The block SHALL have port i_clear, input, 1 bit: synchronous frame flush.
REQ-010 The block SHALL have port o_valid, output, 1 bit: o_acc holds a completed frame sum.
REQ-011 The block SHALL have port i_ready, input, 1 bit: downstream accepts o_acc.
REQ-012 The block SHALL have port o_acc, output, ACC_WIDTH bits: frame sum.
REQ-013 The block SHALL have port o_overflow, output, 1 bit: the frame sum exceeded 2^ACC_WIDTH-1.

Function
REQ-014 An input transfer SHALL occur when i_valid=1 and o_ready=1 at a rising edge; an output transfer SHALL occur when o_valid=1 and i_ready=1 at a rising edge.
REQ-015 The block SHALL implement the states IDLE (count=0), ACCUM (0<count<ACC_LEN) and HOLD (frame complete, o_valid=1).
REQ-016 The block SHALL drive o_ready=1 in IDLE and ACCUM, and o_ready=i_ready in HOLD.
REQ-017 An input transfer in IDLE SHALL load acc=zero-extended i_product and count=1, then enter ACCUM.
REQ-018 An input transfer in ACCUM SHALL set acc=acc+i_product and increment count.
REQ-019 When the ACC_LEN-th transfer occurs, the block SHALL enter HOLD, asserting o_valid on the following cycle (latency 1 cycle from the last input transfer to o_valid).
REQ-020 In HOLD, o_acc and o_overflow SHALL hold stable until an output transfer occurs.
REQ-021 An output transfer with no simultaneous input transfer SHALL return the block to IDLE with acc=0.
REQ-022 An output transfer with a simultaneous input transfer SHALL hand off the old sum and start a new frame with acc=i_product and count=1 (state ACCUM), with no bubble.
REQ-023 The block SHALL support back-to-back input transfers every cycle within a frame.
REQ-024 o_overflow SHALL be sticky within a frame, set on any carry out of bit ACC_WIDTH-1, and cleared at the start of each frame.
REQ-025 When i_clear=1, the block SHALL go to IDLE with acc=0, count=0, o_valid=0 and o_overflow=0 on the next edge, overriding any simultaneous transfer; a product presented that cycle SHALL be discarded.
REQ-026 An ACC_LEN of 1 SHALL be unsupported and SHALL be flagged by an elaboration-time check.

Reset
REQ-027 When i_rst_n=0 at a rising edge, the block SHALL set state=IDLE, count=0, acc=0, o_acc=0, o_valid=0 and o_overflow=0, and o_ready=1 follows from IDLE.
REQ-028 Reset SHALL take priority over i_clear and over all transfers, and SHALL abort a partial frame or pending HOLD without output.

Configuration
REQ-029 With PROD_ACC_SAT_EN defined, on overflow acc SHALL saturate to all-ones, remain saturated for the rest of the frame, and set o_overflow.
REQ-030 With PROD_ACC_SAT_EN undefined, acc SHALL wrap modulo 2^ACC_WIDTH while o_overflow still reports the sticky carry-out.

Verification
REQ-031 With DATA_WIDTH=16, ACC_LEN=4 and ACC_WIDTH=35, back-to-back inputs 1,2,3,4 with i_ready=1 SHALL produce o_valid one cycle after the 4th transfer, o_acc=10 and o_overflow=0.
REQ-032 With i_ready=0 in HOLD, o_ready SHALL be 0, the output SHALL be held stable and i_valid pulses SHALL be ignored; raising i_ready SHALL produce one transfer, then IDLE.
REQ-033 In HOLD with i_ready=1 and i_valid=1 carrying product 7, the old sum SHALL be delivered and the next frame SHALL start with acc=7 and count=1; three further inputs of 1 SHALL yield o_acc=10.
REQ-034 With ACC_WIDTH=32, four inputs of 0xFFFE0001 SHALL yield o_acc=0xFFFFFFFF and o_overflow=1 with PROD_ACC_SAT_EN defined, and o_acc=0xFFF80004 and o_overflow=1 with it undefined.
REQ-035 i_clear after 2 accepted products, followed by a frame of four inputs of 5, SHALL yield o_acc=20.
REQ-036 i_rst_n=0 asserted during HOLD SHALL give o_valid=0, o_ready=1 and o_acc=0 after the next edge, and the next frame SHALL sum correctly.
